led_pattern_sequencer: RTL and testbench
========================================

Name: led_pattern_sequencer

Overview:
- Drives the Go Board's four user LEDs (LED1..LED4) with one of four animated patterns.
- A prescaler converts the board clock into step ticks; a small FSM starts and stops the animation on command.
- Sits between the top-level control logic (buttons or host pulses) and the LED pins. It is the single owner of those pins.

Parameters:
- DIV, 2500000, clock cycles per pattern step (25 MHz clk -> 10 steps/s); legal range 1..2^CNT_W.
- CNT_W, 22, prescaler counter width; must satisfy 2^CNT_W >= DIV.

Ports:
- clk  input  1  system clock (25 MHz on board).
- rstn  input  1  asynchronous active-low reset.
- mode  input  2  pattern select; sampled only on an accepted start.
- start  input  1  single-cycle request to begin animation.
- stop  input  1  single-cycle request to end animation.
- LED1  output  1  pattern bit 0.
- LED2  output  1  pattern bit 1.
- LED3  output  1  pattern bit 2.
- LED4  output  1  pattern bit 3.
- busy  output  1  high while in RUN.
- step  output  1  one-cycle pulse on every pattern advance.

Behaviour:
- Reset (rstn low, asynchronous):
  - State = IDLE; prescaler cnt = 0; pattern p = 4'b0000; latched mode = 0; direction = up.
  - Outputs: LED1..LED4 = 0, busy = 0, step = 0.
  - Release is synchronous to clk.
  - Reset asserted mid-RUN forces all of the above immediately, with no wait for a clock edge.
- LEDk = p[k-1]. All outputs are registered.
- FSM states are IDLE and RUN.
- IDLE:
  - p = 0, cnt held at 0.
  - start=1 at edge k: latch mode, load the initial pattern into p, cnt = 0, state = RUN. busy and the LEDs reflect this right after edge k.
- RUN:
  - cnt increments each cycle.
  - When cnt == DIV-1: cnt wraps to 0, p advances, step = 1 for that one cycle.
  - The first advance occurs DIV cycles after the start edge; subsequent advances follow every DIV cycles.
  - DIV = 1: p advances every cycle and step stays high continuously.
- stop=1 in RUN: next edge goes to IDLE, p = 0, cnt = 0, step = 0, busy = 0.
- stop in IDLE: ignored.
- start while in RUN: ignored. Changing the pattern requires stop, then start.
- start and stop high in the same cycle: stop wins. From IDLE, the result is to remain in IDLE.
- A stop that coincides with a tick: stop wins, there is no final advance, and step = 0.
- mode changes during RUN: ignored, because mode is latched at start.
- Patterns, written as p[3:0]:
  - mode 0 COUNT: initial 0000; p <= p+1 modulo 16; 1111 wraps to 0000.
  - mode 1 ROTATE: initial 0001; rotate left; 1000 -> 0001.
  - mode 2 BOUNCE: initial 0001, direction up.
    - Up: shift left. On reaching 1000, direction flips to down.
    - Down: shift right. On reaching 0001, direction flips to up.
    - Sequence: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, ...
  - mode 3 BLINK: initial 1111; p <= ~p.
- The pattern register never holds a value outside its mode's sequence; p is never 0 in ROTATE or BOUNCE.

Test Plan (bench uses DIV=4, CNT_W=3):
- Reset release, no stimulus for 20 cycles -> LED1..4 = 0, busy = 0, step never asserted.
- COUNT: start with mode=0 at edge 0 -> p = 0000 after edge 0; p = 0001, 0010, 0011 after edges 4, 8, 12; step high exactly one cycle before each of those edges; after 64 cycles p has wrapped to 0000.
- BOUNCE: start with mode=2, observe 8 steps -> p = 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, 0100.
- ROTATE with mode switched to 3 during RUN, plus a second start -> p stays 0001 -> 0010 -> 0100 -> 1000 -> 0001; busy remains 1; mode is not re-latched.
- Stop coinciding with the tick cycle (cnt == 3) in BLINK -> next edge gives p = 0000, busy = 0, step = 0; no further toggles. Start and stop asserted together in IDLE -> remains IDLE.
- rstn pulsed low mid-RUN (between clock edges) in COUNT at p = 0101 -> LEDs = 0 and busy = 0 immediately. After release, a start with mode=1 gives p = 0001.

Source files
------------

// File: rtl/led_pattern_sequencer.sv
// rtl/led_pattern_sequencer.sv - four-LED animated pattern sequencer with prescaled step ticks
//
// Purpose:
//   Drives LED1..LED4 with one of four animations (COUNT, ROTATE, BOUNCE,
//   BLINK). A prescaler divides clk by DIV to produce pattern advances, and
//   a two-state FSM (IDLE/RUN) starts and stops the animation on command.
//
// Ports:
//   clk        in   system clock
//   rstn       in   asynchronous active-low reset
//   mode[1:0]  in   pattern select, latched only when a start is accepted
//   start      in   single-cycle request to begin animation (ignored in RUN)
//   stop       in   single-cycle request to end animation (wins over start)
//   LED1..4    out  pattern bits 0..3 (registered)
//   busy       out  high while in RUN (registered)
//   step       out  high during the cycle in which the pattern advances at
//                   the next edge (registered)

module led_pattern_sequencer #(
  parameter int DIV   = 2500000,
  parameter int CNT_W = 22
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] mode,
  input  logic       start,
  input  logic       stop,
  output logic       LED1,
  output logic       LED2,
  output logic       LED3,
  output logic       LED4,
  output logic       busy,
  output logic       step
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [1:0] MODE_COUNT  = 2'd0;
  localparam logic [1:0] MODE_ROTATE = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_BLINK  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       p_q, p_d;
  logic [1:0]       mode_q, mode_d;
  logic             dir_up_q, dir_up_d;
  logic             busy_q, busy_d;
  logic             step_q, step_d;

  function automatic logic [3:0] init_pattern(input logic [1:0] m);
    case (m)
      MODE_COUNT:  return 4'b0000;
      MODE_ROTATE: return 4'b0001;
      MODE_BOUNCE: return 4'b0001;
      default:     return 4'b1111;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    mode_d   = mode_q;
    dir_up_d = dir_up_q;

    case (state_q)
      IDLE: begin
        p_d   = 4'b0000;
        cnt_d = '0;
        // stop has priority, so start+stop together leaves us in IDLE
        if (start && !stop) begin
          state_d  = RUN;
          mode_d   = mode;
          dir_up_d = 1'b1;
          p_d      = init_pattern(mode);
        end
      end

      RUN: begin
        if (stop) begin
          // stop beats a coincident tick: no final advance
          state_d  = IDLE;
          p_d      = 4'b0000;
          cnt_d    = '0;
          dir_up_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          case (mode_q)
            MODE_COUNT:  p_d = p_q + 4'd1;
            MODE_ROTATE: p_d = {p_q[2:0], p_q[3]};
            MODE_BOUNCE: begin
              // direction flips on the advance that lands on an end bit
              if (dir_up_q) begin
                p_d = {p_q[2:0], 1'b0};
                if (p_q[2]) dir_up_d = 1'b0;
              end else begin
                p_d = {1'b0, p_q[3:1]};
                if (p_q[1]) dir_up_d = 1'b1;
              end
            end
            default:     p_d = ~p_q;
          endcase
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        p_d     = 4'b0000;
        cnt_d   = '0;
      end
    endcase
  end

  // step marks the cycle whose closing edge advances the pattern; with
  // DIV=1 the counter sits at CNT_LAST permanently, so step stays high.
  assign busy_d = (state_d == RUN);
  assign step_d = (state_d == RUN) && (cnt_d == CNT_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      p_q      <= 4'b0000;
      mode_q   <= 2'd0;
      dir_up_q <= 1'b1;
      busy_q   <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      mode_q   <= mode_d;
      dir_up_q <= dir_up_d;
      busy_q   <= busy_d;
      step_q   <= step_d;
    end
  end

  assign LED1 = p_q[0];
  assign LED2 = p_q[1];
  assign LED3 = p_q[2];
  assign LED4 = p_q[3];
  assign busy = busy_q;
  assign step = step_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb/tb_led_pattern_sequencer.sv - self-checking bench for led_pattern_sequencer (DIV=4, CNT_W=3)

module tb_led_pattern_sequencer;

  logic       clk   = 1'b0;
  logic       rstn  = 1'b1;
  logic [1:0] mode  = 2'd0;
  logic       start = 1'b0;
  logic       stop  = 1'b0;
  logic       LED1, LED2, LED3, LED4, busy, step;

  int checks = 0;
  int errors = 0;

  led_pattern_sequencer #(
    .DIV   (4),
    .CNT_W (3)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .mode  (mode),
    .start (start),
    .stop  (stop),
    .LED1  (LED1),
    .LED2  (LED2),
    .LED3  (LED3),
    .LED4  (LED4),
    .busy  (busy),
    .step  (step)
  );

  always #5 clk = ~clk;

  // n: edges to clock with these inputs (start/stop pulse only on the first);
  // expectations are checked 1 time unit after the last of those edges.
  typedef struct {
    string      name;
    int         n;
    logic       start;
    logic       stop;
    logic [1:0] mode;
    logic [3:0] p;
    logic       busy;
    logic       step;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string name, input int n, input logic st, input logic sp,
                     input logic [1:0] m, input logic [3:0] p, input logic b, input logic s);
    vec_t v;
    v.name = name; v.n = n; v.start = st; v.stop = sp; v.mode = m;
    v.p = p; v.busy = b; v.step = s;
    vq.push_back(v);
  endtask

  task automatic check_outs(input string name, input logic [3:0] ep, input logic eb, input logic es);
    logic [3:0] ap;
    ap = {LED4, LED3, LED2, LED1};
    checks++;
    if (ap !== ep) begin
      errors++;
      $display("FAIL %s leds: got %b want %b", name, ap, ep);
    end
    checks++;
    if (busy !== eb) begin
      errors++;
      $display("FAIL %s busy: got %b want %b", name, busy, eb);
    end
    checks++;
    if (step !== es) begin
      errors++;
      $display("FAIL %s step: got %b want %b", name, step, es);
    end
  endtask

  task automatic run_q();
    foreach (vq[i]) begin
      start = vq[i].start;
      stop  = vq[i].stop;
      mode  = vq[i].mode;
      for (int k = 0; k < vq[i].n; k++) begin
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
      end
      check_outs(vq[i].name, vq[i].p, vq[i].busy, vq[i].step);
    end
    vq.delete();
  endtask

  initial begin
    // reset state, then 20 idle cycles with no stimulus
    #1 rstn = 1'b0;
    #1 check_outs("reset", 4'b0000, 1'b0, 1'b0);
    #20 rstn = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      check_outs("idle_quiet", 4'b0000, 1'b0, 1'b0);
    end

    // COUNT: advances at edges 4, 8, 12; step in the cycle before each
    add("cnt_start",  1, 1, 0, 2'd0, 4'b0000, 1, 0);
    add("cnt_tick1",  3, 0, 0, 2'd0, 4'b0000, 1, 1);
    add("cnt_adv1",   1, 0, 0, 2'd0, 4'b0001, 1, 0);
    add("cnt_tick2",  3, 0, 0, 2'd0, 4'b0001, 1, 1);
    add("cnt_adv2",   1, 0, 0, 2'd0, 4'b0010, 1, 0);
    add("cnt_tick3",  3, 0, 0, 2'd0, 4'b0010, 1, 1);
    add("cnt_adv3",   1, 0, 0, 2'd0, 4'b0011, 1, 0);
    add("cnt_e63",   51, 0, 0, 2'd0, 4'b1111, 1, 1);
    add("cnt_wrap",   1, 0, 0, 2'd0, 4'b0000, 1, 0);
    add("cnt_stop",   1, 0, 1, 2'd0, 4'b0000, 0, 0);
    add("stop_idle",  2, 0, 1, 2'd0, 4'b0000, 0, 0);
    // BOUNCE: 8 steps after the initial pattern
    add("bnc_start",  1, 1, 0, 2'd2, 4'b0001, 1, 0);
    add("bnc_s1",     4, 0, 0, 2'd2, 4'b0010, 1, 0);
    add("bnc_s2",     4, 0, 0, 2'd2, 4'b0100, 1, 0);
    add("bnc_s3",     4, 0, 0, 2'd2, 4'b1000, 1, 0);
    add("bnc_s4",     4, 0, 0, 2'd2, 4'b0100, 1, 0);
    add("bnc_s5",     4, 0, 0, 2'd2, 4'b0010, 1, 0);
    add("bnc_s6",     4, 0, 0, 2'd2, 4'b0001, 1, 0);
    add("bnc_s7",     4, 0, 0, 2'd2, 4'b0010, 1, 0);
    add("bnc_s8",     4, 0, 0, 2'd2, 4'b0100, 1, 0);
    add("bnc_stop",   1, 0, 1, 2'd2, 4'b0000, 0, 0);
    // ROTATE, then mode=3 and a second start during RUN are ignored
    add("rot_start",  1, 1, 0, 2'd1, 4'b0001, 1, 0);
    add("rot_restart",1, 1, 0, 2'd3, 4'b0001, 1, 0);
    add("rot_tick",   2, 0, 0, 2'd3, 4'b0001, 1, 1);
    add("rot_s1",     1, 0, 0, 2'd3, 4'b0010, 1, 0);
    add("rot_s2",     4, 0, 0, 2'd3, 4'b0100, 1, 0);
    add("rot_s3",     4, 0, 0, 2'd3, 4'b1000, 1, 0);
    add("rot_s4",     4, 0, 0, 2'd3, 4'b0001, 1, 0);
    add("rot_s5",     4, 0, 0, 2'd3, 4'b0010, 1, 0);
    add("rot_stop",   1, 0, 1, 2'd3, 4'b0000, 0, 0);
    // BLINK, stop lands on the second tick cycle (p=0000 there)
    add("blk_start",  1, 1, 0, 2'd3, 4'b1111, 1, 0);
    add("blk_tick1",  3, 0, 0, 2'd3, 4'b1111, 1, 1);
    add("blk_tog1",   1, 0, 0, 2'd3, 4'b0000, 1, 0);
    add("blk_tick2",  3, 0, 0, 2'd3, 4'b0000, 1, 1);
    add("blk_stoptk", 1, 0, 1, 2'd3, 4'b0000, 0, 0);
    add("blk_after",  6, 0, 0, 2'd3, 4'b0000, 0, 0);
    // start and stop together in IDLE
    add("both_idle",  1, 1, 1, 2'd1, 4'b0000, 0, 0);
    add("both_after", 5, 0, 0, 2'd1, 4'b0000, 0, 0);
    // COUNT up to p=0101 (edge 20)
    add("pre_rst_st", 1, 1, 0, 2'd0, 4'b0000, 1, 0);
    add("pre_rst_p5",20, 0, 0, 2'd0, 4'b0101, 1, 0);
    run_q();

    // asynchronous reset between edges, then release before the next edge
    #2 rstn = 1'b0;
    #1 check_outs("async_rst", 4'b0000, 1'b0, 1'b0);
    #2 rstn = 1'b1;

    add("post_rst_st",1, 1, 0, 2'd1, 4'b0001, 1, 0);
    add("post_tick",  3, 0, 0, 2'd1, 4'b0001, 1, 1);
    add("post_adv",   1, 0, 0, 2'd1, 4'b0010, 1, 0);
    run_q();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
